// File: rtl/ship_placer_if.sv
// Handshake and occupancy-map bundle between the fleet placer and its consumer.
// The consumer holds the master modport and drives start; the placer holds slave.
interface ship_placer_if;
  logic        start;
  logic [99:0] is_ship;
  logic        busy;
  logic        done;
  logic        fail;
  logic [2:0]  ships_placed;

  modport master (
    output start,
    input  is_ship, busy, done, fail, ships_placed
  );

  modport slave (
    input  start,
    output is_ship, busy, done, fail, ships_placed
  );
endinterface

// File: rtl/ship_placer.sv
// Randomised placement of a 5/4/3/3/2 fleet on a 10x10 grid (index = row*10 + col).
// A free-running LFSR proposes candidates, which are checked and then committed one cell per cycle.
module ship_placer #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int unsigned MAX_TRIES = 255
) (
  input  logic          clk,
  input  logic          reset,
  ship_placer_if.slave  bus
);

  localparam logic [15:0] SEED_EFF    = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [7:0]  TRY_LIMIT   = 8'(MAX_TRIES);
  // Fallback fleet: bits 4:0, 15:12, 22:20, 33:31, 44:43.
  localparam logic [99:0] DEFAULT_MAP = 100'h0000_0000_0000_1803_8070_F01F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAW,
    S_CHECK,
    S_COMMIT,
    S_DONE
  } state_t;

  function automatic logic [2:0] ship_size(input logic [2:0] idx);
    case (idx)
      3'd0:    ship_size = 3'd5;
      3'd1:    ship_size = 3'd4;
      3'd2:    ship_size = 3'd3;
      3'd3:    ship_size = 3'd3;
      default: ship_size = 3'd2;
    endcase
  endfunction

  state_t      state_q;
  logic [15:0] lfsr_q;
  logic [99:0] is_ship_q;
  logic        busy_q;
  logic        done_q;
  logic        fail_q;
  logic [2:0]  ships_q;
  logic [7:0]  try_q;
  logic [2:0]  ship_idx_q;
  logic [2:0]  k_q;
  logic [6:0]  base_q;
  logic [6:0]  addr_q;
  logic [6:0]  step_q;

  logic [15:0] lfsr_d;
  logic [3:0]  cand_col_d;
  logic [3:0]  cand_row_d;
  logic        cand_vert_d;
  logic [2:0]  size_d;
  logic [4:0]  col_end_d;
  logic [4:0]  row_end_d;
  logic        cand_ok_d;
  logic [6:0]  cand_base_d;
  logic        last_cell_d;
  logic        reject_d;
  logic [7:0]  try_inc_d;
  logic        exhaust_d;

  always_comb begin
    lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    cand_col_d  = lfsr_q[3:0];
    cand_row_d  = lfsr_q[7:4];
    cand_vert_d = lfsr_q[8];
    size_d      = ship_size(ship_idx_q);
    col_end_d   = {1'b0, cand_col_d} + {2'b00, size_d};
    row_end_d   = {1'b0, cand_row_d} + {2'b00, size_d};
    cand_ok_d   = (cand_col_d <= 4'd9) && (cand_row_d <= 4'd9) &&
                  (cand_vert_d ? (row_end_d <= 5'd10) : (col_end_d <= 5'd10));
    // row*10 as (row<<3)+(row<<1); only meaningful once the candidate is valid.
    cand_base_d = {cand_row_d, 3'b000} + {2'b00, cand_row_d, 1'b0} + {3'b000, cand_col_d};
    last_cell_d = (k_q == (size_d - 3'd1));
    reject_d    = ((state_q == S_DRAW) && !cand_ok_d) ||
                  ((state_q == S_CHECK) && is_ship_q[addr_q]);
    try_inc_d   = try_q + 8'd1;
    exhaust_d   = (try_inc_d == TRY_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      lfsr_q     <= SEED_EFF;
      is_ship_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      ships_q    <= 3'd0;
      try_q      <= 8'd0;
      ship_idx_q <= 3'd0;
      k_q        <= 3'd0;
      base_q     <= 7'd0;
      addr_q     <= 7'd0;
      step_q     <= 7'd0;
    end else begin
      lfsr_q <= lfsr_d;
      if (reject_d) begin
        if (exhaust_d) begin
          is_ship_q <= DEFAULT_MAP;
          ships_q   <= 3'd5;
          fail_q    <= 1'b1;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          state_q   <= S_DONE;
        end else begin
          try_q   <= try_inc_d;
          state_q <= S_DRAW;
        end
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (bus.start) begin
              is_ship_q  <= '0;
              ships_q    <= 3'd0;
              fail_q     <= 1'b0;
              try_q      <= 8'd0;
              ship_idx_q <= 3'd0;
              busy_q     <= 1'b1;
              done_q     <= 1'b0;
              state_q    <= S_DRAW;
            end
          end
          S_DRAW: begin
            base_q  <= cand_base_d;
            addr_q  <= cand_base_d;
            step_q  <= cand_vert_d ? 7'd10 : 7'd1;
            k_q     <= 3'd0;
            state_q <= S_CHECK;
          end
          S_CHECK: begin
            if (last_cell_d) begin
              k_q     <= 3'd0;
              addr_q  <= base_q;
              state_q <= S_COMMIT;
            end else begin
              k_q    <= k_q + 3'd1;
              addr_q <= addr_q + step_q;
            end
          end
          S_COMMIT: begin
            is_ship_q[addr_q] <= 1'b1;
            if (last_cell_d) begin
              ships_q <= ships_q + 3'd1;
              if (ship_idx_q == 3'd4) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                ship_idx_q <= ship_idx_q + 3'd1;
                state_q    <= S_DRAW;
              end
            end else begin
              k_q    <= k_q + 3'd1;
              addr_q <= addr_q + step_q;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.is_ship      = is_ship_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.fail         = fail_q;
  assign bus.ships_placed = ships_q;

endmodule
